// File: rtl/mips_mem_pkg.sv
// Shared types and sizing for the unified instruction/data memory port.
package mips_mem_pkg;

  localparam int MEM_WORDS = 1024;
  localparam int AW_DEF    = $clog2(MEM_WORDS);
  localparam int DW_DEF    = 32;

  // Who owns the read data that emerges from the RAM a few cycles later.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_resp_tag_pipe.sv
// Owner-tag delay line that tracks in-flight RAM reads. A tag pushed in the
// grant cycle reaches the tail exactly DEPTH cycles later, lined up with
// ram_rdata. kill_if retires every in-flight fetch tag, including the one
// sitting at the tail this cycle.
module arb_resp_tag_pipe
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       kill_if,
  input  logic [1:0] push_tag,
  output logic [1:0] tail_tag
);

  owner_t tag_q [DEPTH];
  owner_t tag_d [DEPTH];
  owner_t push_t;

  assign push_t = owner_t'(push_tag);

  // Shift one stage per cycle, turning fetch tags into NONE when killed.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) tag_d[i] = OWN_NONE;
    tag_d[0] = (kill_if && push_t == OWN_IF) ? OWN_NONE : push_t;
    for (int i = 1; i < DEPTH; i++) begin
      tag_d[i] = (kill_if && tag_q[i-1] == OWN_IF) ? OWN_NONE : tag_q[i-1];
    end
  end

  // Tag register; clear forgets every read issued before it.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= OWN_NONE;
    end else begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
    end
  end

  // Tail is masked while clearing and when a fetch response is being killed.
  always_comb begin
    if (clr || (kill_if && tag_q[DEPTH-1] == OWN_IF)) tail_tag = OWN_NONE;
    else                                               tail_tag = tag_q[DEPTH-1];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data stage.
//
// Handshake: a requester raises *_req with stable address/data and holds it
// until it sees *_gnt in the same cycle; the grant cycle is the transfer
// cycle. Read data returns RAM_LAT cycles later with a one-cycle *_rvalid
// (no back-pressure on responses). Writes complete at grant and return
// nothing.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int RAM_LAT      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          stall_if,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int            SW         = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  owner_t        push_tag;
  logic [1:0]    tail_tag;

  // Grant selection: flush blocks fetch, then starvation guard, data, fetch.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst) begin
      if (if_flush)                               dm_gnt = dm_req;
      else if (if_req && streak_q == STREAK_MAX)  if_gnt = 1'b1;
      else if (dm_req)                            dm_gnt = 1'b1;
      else if (if_req)                            if_gnt = 1'b1;
    end
  end

  // Count data grants that made a waiting fetch wait; saturates at the limit.
  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt)                     streak_d = '0;
    else if (dm_gnt && streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
  end

  // Streak register.
  always_ff @(posedge clk1) begin
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end

  // Drive the RAM command in the grant cycle and pick the response owner.
  always_comb begin
    ram_en    = if_gnt | dm_gnt;
    ram_we    = dm_gnt & dm_we;
    ram_addr  = '0;
    ram_wdata = '0;
    push_tag  = OWN_NONE;
    if (dm_gnt) begin
      ram_addr = dm_addr;
      if (dm_we) ram_wdata = dm_wdata;
      else       push_tag  = OWN_DM;
    end else if (if_gnt) begin
      ram_addr = if_addr;
      push_tag = OWN_IF;
    end
  end

  arb_resp_tag_pipe #(
    .DEPTH (RAM_LAT)
  ) u_tag_pipe (
    .clk      (clk1),
    .clr      (rst),
    .kill_if  (if_flush),
    .push_tag (push_tag),
    .tail_tag (tail_tag)
  );

  // Route read data to whoever owns the tail tag; report fetch stalls.
  always_comb begin
    if_rvalid = (tail_tag == OWN_IF);
    dm_rvalid = (tail_tag == OWN_DM);
    if_rdata  = rst ? '0 : ram_rdata;
    dm_rdata  = rst ? '0 : ram_rdata;
    stall_if  = if_req & ~if_gnt & ~rst;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance per legal RAM latency, both fed the
// same requests, each with its own RAM model. A timestamped response queue
// predicts what each port should see.
module tb_mem_port_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int MAX_D = 4;
  localparam int EW    = 51; // {lat_idx[50], due[49:34], owner[33:32], data[31:0]}
  localparam logic [1:0] O_IF = 2'd1;
  localparam logic [1:0] O_DM = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst      = 1'b1;
  logic          if_req   = 1'b0;
  logic          if_flush = 1'b0;
  logic          dm_req   = 1'b0;
  logic          dm_we    = 1'b0;
  logic [AW-1:0] if_addr  = '0;
  logic [AW-1:0] dm_addr  = '0;
  logic [DW-1:0] dm_wdata = '0;

  logic          if_gnt1, if_rvalid1, dm_gnt1, dm_rvalid1, stall_if1, ram_en1, ram_we1;
  logic [DW-1:0] if_rdata1, dm_rdata1, ram_wdata1;
  logic [AW-1:0] ram_addr1;
  logic [DW-1:0] ram_rdata1 = '0;

  logic          if_gnt2, if_rvalid2, dm_gnt2, dm_rvalid2, stall_if2, ram_en2, ram_we2;
  logic [DW-1:0] if_rdata2, dm_rdata2, ram_wdata2;
  logic [AW-1:0] ram_addr2;
  logic [DW-1:0] ram_rdata2 = '0;
  logic [DW-1:0] rd2a       = '0;

  mem_port_arbiter #(.RAM_LAT(1)) u_dut1 (
    .clk1(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
    .stall_if(stall_if1), .ram_en(ram_en1), .ram_we(ram_we1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
  );

  mem_port_arbiter #(.RAM_LAT(2)) u_dut2 (
    .clk1(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt2), .if_rvalid(if_rvalid2), .if_rdata(if_rdata2),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt2), .dm_rvalid(dm_rvalid2), .dm_rdata(dm_rdata2),
    .stall_if(stall_if2), .ram_en(ram_en2), .ram_we(ram_we2),
    .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2)
  );

  // ---------------- memories and reference state ----------------
  logic [DW-1:0] mem1    [1024];
  logic [DW-1:0] mem2    [1024];
  logic [DW-1:0] ref_mem [1024];

  logic          c_en1, c_we1, c_en2, c_we2;
  logic [AW-1:0] c_addr1, c_addr2;
  logic [DW-1:0] c_wd1, c_wd2;

  logic [EW-1:0] exp_q [$];
  int            m_streak = 0;
  int            cyc      = 0;
  logic          m_ig     = 1'b0;
  logic          m_dg     = 1'b0;
  int            n_checks = 0;
  int            n_pass   = 0;

  // ---------------- scoreboard ----------------
  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  task automatic check_dut(string s, logic ig, logic dg, logic st, logic en, logic we,
                           logic [AW-1:0] ad, logic [DW-1:0] wd,
                           logic iv, logic [DW-1:0] id, logic dv, logic [DW-1:0] dd,
                           logic [1:0] eo, logic [DW-1:0] ed);
    logic e_st;
    e_st = !rst && if_req && !m_ig;
    check_eq({"if_gnt", s},    64'(ig), 64'(m_ig));
    check_eq({"dm_gnt", s},    64'(dg), 64'(m_dg));
    check_eq({"stall_if", s},  64'(st), 64'(e_st));
    check_eq({"ram_en", s},    64'(en), 64'(m_ig || m_dg));
    check_eq({"ram_we", s},    64'(we), 64'(m_dg && dm_we));
    if (m_ig || m_dg)
      check_eq({"ram_addr", s}, 64'(ad), 64'(m_dg ? dm_addr : if_addr));
    if (m_dg && dm_we)
      check_eq({"ram_wdata", s}, 64'(wd), 64'(dm_wdata));
    if (rst) begin
      check_eq({"rst_ram_addr", s},  64'(ad), 64'(0));
      check_eq({"rst_ram_wdata", s}, 64'(wd), 64'(0));
      check_eq({"rst_if_rdata", s},  64'(id), 64'(0));
      check_eq({"rst_dm_rdata", s},  64'(dd), 64'(0));
    end
    check_eq({"if_rvalid", s}, 64'(iv), 64'(eo == O_IF));
    check_eq({"dm_rvalid", s}, 64'(dv), 64'(eo == O_DM));
    if (eo == O_IF) check_eq({"if_rdata", s}, 64'(id), 64'(ed));
    if (eo == O_DM) check_eq({"dm_rdata", s}, 64'(dd), 64'(ed));
  endtask

  // Reference model: rules evaluated per cycle, reads become timestamped
  // entries that are due `latency` cycles after their grant.
  task automatic model_check();
    logic [EW-1:0] keep_q [$];
    logic [1:0]    e_own [2];
    logic [DW-1:0] e_dat [2];
    logic [AW-1:0] a;
    logic [1:0]    own;
    e_own[0] = 2'd0; e_own[1] = 2'd0;
    e_dat[0] = '0;   e_dat[1] = '0;

    m_ig = 1'b0;
    m_dg = 1'b0;
    if (!rst) begin
      if (if_flush)                        m_dg = dm_req;
      else if (if_req && m_streak >= MAX_D) m_ig = 1'b1;
      else if (dm_req)                     m_dg = 1'b1;
      else if (if_req)                     m_ig = 1'b1;
    end

    keep_q = {};
    foreach (exp_q[i]) begin
      if (rst) continue;
      if (if_flush && exp_q[i][33:32] == O_IF) continue;
      if (exp_q[i][49:34] == cyc[15:0]) begin
        e_own[int'(exp_q[i][50])] = exp_q[i][33:32];
        e_dat[int'(exp_q[i][50])] = exp_q[i][31:0];
        continue;
      end
      keep_q.push_back(exp_q[i]);
    end
    exp_q = keep_q;

    c_en1 = ram_en1; c_we1 = ram_we1; c_addr1 = ram_addr1; c_wd1 = ram_wdata1;
    c_en2 = ram_en2; c_we2 = ram_we2; c_addr2 = ram_addr2; c_wd2 = ram_wdata2;

    check_dut("/L1", if_gnt1, dm_gnt1, stall_if1, ram_en1, ram_we1, ram_addr1, ram_wdata1,
              if_rvalid1, if_rdata1, dm_rvalid1, dm_rdata1, e_own[0], e_dat[0]);
    check_dut("/L2", if_gnt2, dm_gnt2, stall_if2, ram_en2, ram_we2, ram_addr2, ram_wdata2,
              if_rvalid2, if_rdata2, dm_rvalid2, dm_rdata2, e_own[1], e_dat[1]);

    if (rst || !if_req || m_ig)          m_streak = 0;
    else if (m_dg && m_streak < MAX_D)   m_streak++;

    if (m_ig || (m_dg && !dm_we)) begin
      a   = m_dg ? dm_addr : if_addr;
      own = m_dg ? O_DM : O_IF;
      for (int l = 0; l < 2; l++)
        exp_q.push_back({l[0], 16'(cyc + l + 1), own, ref_mem[a]});
    end
    if (m_dg && dm_we) ref_mem[dm_addr] = dm_wdata;
    cyc++;
  endtask

  // RAM behaviour at the clock edge, from commands captured mid-cycle.
  task automatic ram_update();
    if (c_en1 && c_we1)  mem1[c_addr1] = c_wd1;
    else if (c_en1)      ram_rdata1 = mem1[c_addr1];
    ram_rdata2 = rd2a;
    if (c_en2 && c_we2)  mem2[c_addr2] = c_wd2;
    else if (c_en2)      rd2a = mem2[c_addr2];
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    ram_update();
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(bit r, bit ir, int ia, bit fl, bit dr, bit we, int da, logic [DW-1:0] wd);
    rst      = r;
    if_req   = ir;
    if_addr  = AW'(ia);
    if_flush = fl;
    dm_req   = dr;
    dm_we    = we;
    dm_addr  = AW'(da);
    dm_wdata = wd;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i]    = $urandom;
      mem2[i]    = mem1[i];
      ref_mem[i] = mem1[i];
    end

    // Reset with requests asserted: everything must stay quiet.
    drive(1, 1, 0, 0, 1, 0, 5, '0);
    drive(1, 1, 0, 0, 1, 0, 5, '0);
    idle(1);

    // Fetch-only stream 0,1,2.
    drive(0, 1, 0, 0, 0, 0, 0, '0);
    drive(0, 1, 1, 0, 0, 0, 0, '0);
    drive(0, 1, 2, 0, 0, 0, 0, '0);
    idle(3);

    // Contention: data load wins, fetch follows.
    drive(0, 1, 3, 0, 1, 0, 'h200, '0);
    drive(0, 1, 3, 0, 0, 0, 0, '0);
    idle(3);

    // Starvation guard: 6 cycles of data requests with fetch waiting.
    for (int i = 0; i < 6; i++) drive(0, 1, 5, 0, 1, 0, 'h40 + i, '0);
    idle(3);

    // Store then load, then load through a wrapped address.
    drive(0, 0, 0, 0, 1, 1, 'h3FF, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 1, 0, 'h3FF, '0);
    idle(2);
    drive(0, 0, 0, 0, 1, 0, 'h7FF, '0);
    idle(3);

    // Flush the cycle after a fetch grant.
    drive(0, 1, 7, 0, 0, 0, 0, '0);
    drive(0, 1, 8, 1, 0, 0, 0, '0);
    drive(0, 1, 8, 0, 0, 0, 0, '0);
    idle(3);

    // Flush two cycles later: a data load in flight must survive.
    drive(0, 0, 0, 0, 1, 0, 'h20, '0);
    drive(0, 1, 11, 0, 0, 0, 0, '0);
    drive(0, 0, 0, 1, 1, 0, 'h21, '0);
    idle(3);

    // Reset right after a load grant.
    drive(0, 0, 0, 0, 1, 0, 'h100, '0);
    drive(1, 1, 12, 0, 1, 0, 'h101, '0);
    drive(0, 1, 12, 0, 1, 0, 'h101, '0);
    drive(0, 1, 12, 0, 0, 0, 0, '0);
    idle(3);

    // Random traffic; requests stay up until the model says they were granted.
    for (int n = 0; n < 600; n++) begin
      if (!if_req || m_ig) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = AW'($urandom_range(0, 31));
      end
      if (!dm_req || m_dg) begin
        dm_req   = ($urandom_range(0, 1) != 0);
        dm_we    = ($urandom_range(0, 1) != 0);
        dm_addr  = AW'($urandom_range(0, 31));
        dm_wdata = $urandom;
      end
      if_flush = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      step();
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single-port unified instruction/data memory (1024 x 32-bit words) between the fetch stage (read-only) and the data-memory stage (read/write).
- Issues at most one RAM command per cycle and routes read data back to its owner after a fixed RAM latency.
- Drops fetch responses cancelled by a taken branch or jump, and raises a stall to the pipeline controller whenever fetch is denied.

Parameters:
- AW, 10, word-address width (memory depth 2^AW words).
- DW, 32, data width.
- RAM_LAT, 1, RAM read latency in cycles (legal values: 1 or 2).
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch request is pending.

Ports:
- clk1  in  1  single clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch read request, held until granted
- if_addr  in  AW  fetch word address
- if_flush  in  1  branch/jump taken: cancel in-flight fetch responses
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- dm_req  in  1  data request, held until granted
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data word address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  load data valid
- dm_rdata  out  DW  load data
- stall_if  out  1  if_req pending and not granted this cycle
- ram_en  out  1  RAM command strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid RAM_LAT cycles after ram_en with ram_we=0

Behaviour:
- Grant logic is combinational from the requests and registered state. Only one of if_gnt and dm_gnt is high in any cycle.
- The RAM command appears on ram_* in the same cycle as the grant.
- Priority, applied in order:
  1. if_flush=1: if_gnt=0. dm may still be granted.
  2. streak==MAX_D_STREAK and if_req=1: grant fetch.
  3. dm_req=1: grant data.
  4. if_req=1: grant fetch.
- Streak counter:
  - Increments on a dm grant while if_req=1.
  - Clears on any fetch grant, or on any cycle with if_req=0.
  - Saturates at MAX_D_STREAK.
- Responses:
  - Every granted read pushes an owner tag (NONE/IF/DM) into a RAM_LAT-deep tag shift register.
  - Writes and idle cycles push NONE.
  - At the tail: tag IF -> if_rvalid=1 and if_rdata=ram_rdata; tag DM -> dm_rvalid=1 and dm_rdata=ram_rdata.
  - rdata buses are passed through from ram_rdata; they are don't-care when rvalid=0.
- Write completion: a write completes at grant. No rvalid is generated for writes.
- Flush: if_flush=1 rewrites every in-flight IF tag to NONE. Any response that would have emerged in the current cycle is suppressed (if_rvalid=0). DM tags are unaffected.
- stall_if = if_req & ~if_gnt, including cycles where fetch is denied because of if_flush.
- Addresses wrap modulo 2^AW. No range checking.
- Reset:
  - All tags go to NONE and the streak counter to 0.
  - if_gnt, dm_gnt, if_rvalid, dm_rvalid, stall_if, ram_en and ram_we are all 0 during the rst cycle, regardless of requests.
  - No rvalid is produced after reset for reads issued before it.
  - ram_addr, ram_wdata and the rdata buses reset to 0.
- Simultaneous dm_req and if_req with streak < MAX_D_STREAK: data wins and stall_if=1.

Decomposition:
- Package mips_mem_pkg holds:
  - owner_t enum {OWN_NONE, OWN_IF, OWN_DM}
  - AW/DW defaults
  - MEM_WORDS=1024
- One sub-module, arb_resp_tag_pipe: parameterised RAM_LAT-deep owner-tag shift register with synchronous clear and IF-tag kill input.

Test Plan:
- Fetch-only stream: if_req=1 with addresses 0,1,2 -> if_gnt every cycle, stall_if=0; if_rvalid one cycle later carrying mem[0], mem[1], mem[2].
- Contention: if_req=1 and dm_req=1 (load, addr 0x200) in the same cycle -> dm_gnt=1, stall_if=1; dm_rvalid next cycle with mem[0x200]; fetch granted the following cycle.
- Starvation guard, MAX_D_STREAK=4: dm_req held high for 6 cycles with if_req high -> dm granted on cycles 1-4, if_gnt on cycle 5, dm on cycle 6.
- Store then load: write 0xDEADBEEF to 0x3FF, then read 0x3FF -> no rvalid for the write; dm_rdata=0xDEADBEEF. Repeat with address 0x7FF (wraps to 0x3FF) -> same data.
- Flush: fetch granted at cycle t, if_flush=1 at t+1 (RAM_LAT=1 and RAM_LAT=2) -> no if_rvalid for that read; if_gnt=0 at t+1.
- Reset mid-read: dm load granted, rst=1 the next cycle -> dm_rvalid=0, all grants 0 and ram_en=0 during reset; normal arbitration resumes the cycle after rst deasserts.
